// File: rtl/time_disp_pkg.sv
// rtl/time_disp_pkg.sv - shared types and constants for the MM.SS display driver
//
// Purpose : conversion FSM state encoding, 7-segment codes ({g,f,e,d,c,b,a},
//           active-high), the per-field clamp value and digit positions.
// Ports   : none (package)
package time_disp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [5:0] MAX_FIELD = 6'd59;

  localparam int DIG_SEC_ONES = 0;
  localparam int DIG_SEC_TENS = 1;
  localparam int DIG_MIN_ONES = 2;
  localparam int DIG_MIN_TENS = 3;

  // Out-of-range fields (60..63) display as 59 rather than wrapping.
  function automatic logic [5:0] clamp_field(input logic [5:0] v);
    return (v > MAX_FIELD) ? MAX_FIELD : v;
  endfunction

endpackage

// File: rtl/time_disp_driver_if.sv
// rtl/time_disp_driver_if.sv - time word load handshake between time source and display driver
//
// Purpose : carries the binary time word, its load strobe and the busy flag.
// Signals : time_to_decode[11:0] {min[11:6], sec[5:0]}
//           load                 1-cycle sample request
//           busy                 conversion in progress
// Modports: master (time source), slave (display driver)
interface time_disp_driver_if;
  logic [11:0] time_to_decode;
  logic        load;
  logic        busy;

  modport master (output time_to_decode, output load, input  busy);
  modport slave  (input  time_to_decode, input  load, output busy);
endinterface

// File: rtl/time_disp_driver_seg7_encode.sv
// rtl/time_disp_driver_seg7_encode.sv - combinational BCD to 7-segment encoder
//
// Purpose : maps one BCD digit to {g,f,e,d,c,b,a}, active-high; blank forces all off.
// Ports   : bcd[3:0] in, blank in, seg[6:0] out
module seg7_encode
  import time_disp_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (bcd)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/time_disp_driver.sv
// rtl/time_disp_driver.sv - MM.SS 4-digit multiplexed 7-segment driver with sequential BCD conversion
//
// Purpose : samples a binary {min,sec} word on load, converts each field to BCD by
//           repeated subtraction of 10, commits all four digits at once, and scans
//           them onto a multiplexed display. Optional macro DISP_LZ_BLANK_EN blanks
//           the minutes-tens digit when it is zero.
// Ports   : clk, rst (sync, active-high)
//           bus  time_disp_driver_if.slave (time_to_decode, load, busy)
//           seg[6:0] {g,f,e,d,c,b,a}, dp (MM/SS separator), an[3:0] one-hot digit enable
module time_disp_driver
  import time_disp_pkg::*;
#(
  parameter  int SCAN_DIV = 1000,
  localparam int CNT_W    = $clog2(SCAN_DIV)
) (
  input  logic                clk,
  input  logic                rst,
  time_disp_driver_if.slave   bus,
  output logic [6:0]          seg,
  output logic                dp,
  output logic [3:0]          an
);

  state_t           state_q,    state_d;
  logic             pending_q,  pending_d;
  logic             busy_q,     busy_d;
  logic [5:0]       min_rem_q,  min_rem_d;
  logic [5:0]       sec_rem_q,  sec_rem_d;
  logic [3:0]       min_tens_q, min_tens_d;
  logic [3:0]       sec_tens_q, sec_tens_d;
  logic [3:0][3:0]  disp_q,     disp_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [3:0]       an_q,       an_d;
  logic [6:0]       seg_q,      seg_d;
  logic             dp_q,       dp_d;

  logic [3:0]       act_digit;
  logic             act_blank;

  // Conversion FSM
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    busy_d     = busy_q;
    min_rem_d  = min_rem_q;
    sec_rem_d  = sec_rem_q;
    min_tens_d = min_tens_q;
    sec_tens_d = sec_tens_q;
    disp_d     = disp_q;

    // A load outside IDLE is remembered; the word itself is sampled when IDLE consumes it.
    if (bus.load && (state_q != IDLE)) begin
      pending_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (bus.load || pending_q) begin
          min_rem_d  = clamp_field(bus.time_to_decode[11:6]);
          sec_rem_d  = clamp_field(bus.time_to_decode[5:0]);
          min_tens_d = 4'd0;
          sec_tens_d = 4'd0;
          pending_d  = 1'b0;
          busy_d     = 1'b1;
          state_d    = CONV;
        end else begin
          busy_d = 1'b0;
        end
      end
      CONV: begin
        if ((min_rem_q < 6'd10) && (sec_rem_q < 6'd10)) begin
          state_d = COMMIT;
        end else begin
          if (min_rem_q >= 6'd10) begin
            min_rem_d  = min_rem_q - 6'd10;
            min_tens_d = min_tens_q + 4'd1;
          end
          if (sec_rem_q >= 6'd10) begin
            sec_rem_d  = sec_rem_q - 6'd10;
            sec_tens_d = sec_tens_q + 4'd1;
          end
        end
      end
      COMMIT: begin
        disp_d[DIG_SEC_ONES] = sec_rem_q[3:0];
        disp_d[DIG_SEC_TENS] = sec_tens_q;
        disp_d[DIG_MIN_ONES] = min_rem_q[3:0];
        disp_d[DIG_MIN_TENS] = min_tens_q;
        state_d              = IDLE;
        // Stay busy straight through when another conversion is already queued.
        busy_d               = pending_q | bus.load;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Digit scan, independent of the conversion
  always_comb begin
    if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
      cnt_d = '0;
      an_d  = {an_q[2:0], an_q[3]};
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      an_d  = an_q;
    end
  end

  // seg/dp are computed from the next an and next digits so the registered
  // outputs always agree with the registered an.
  always_comb begin
    case (an_d)
      4'b0010: act_digit = disp_d[DIG_SEC_TENS];
      4'b0100: act_digit = disp_d[DIG_MIN_ONES];
      4'b1000: act_digit = disp_d[DIG_MIN_TENS];
      default: act_digit = disp_d[DIG_SEC_ONES];
    endcase
`ifdef DISP_LZ_BLANK_EN
    act_blank = (an_d == 4'b1000) && (disp_d[DIG_MIN_TENS] == 4'd0);
`else
    act_blank = 1'b0;
`endif
    dp_d = (an_d == 4'b0100);
  end

  seg7_encode u_seg7_encode (
    .bcd   (act_digit),
    .blank (act_blank),
    .seg   (seg_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pending_q  <= 1'b0;
      busy_q     <= 1'b0;
      min_rem_q  <= '0;
      sec_rem_q  <= '0;
      min_tens_q <= '0;
      sec_tens_q <= '0;
      disp_q     <= '0;
      cnt_q      <= '0;
      an_q       <= 4'b0001;
      seg_q      <= SEG_0;
      dp_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      busy_q     <= busy_d;
      min_rem_q  <= min_rem_d;
      sec_rem_q  <= sec_rem_d;
      min_tens_q <= min_tens_d;
      sec_tens_q <= sec_tens_d;
      disp_q     <= disp_d;
      cnt_q      <= cnt_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign bus.busy = busy_q;
  assign seg      = seg_q;
  assign dp       = dp_q;
  assign an       = an_q;

endmodule
